wb_write_queue: RTL and testbench
=================================

# wb_write_queue

Write-back queue between the MEM/WB result path and the register file write port of the THCO-MIPS core. It accepts completed results with a valid/ready handshake and buffers them in order. It drains one entry per cycle into the register file write port (enable/address/data) and exports a per-register pending vector so the decode stage can detect hazards. With the forwarding feature compiled in, it also exports the youngest buffered value for a lookup address.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- DATA_W, 16, result width (`RegBus`)
- ADDR_W, 4, register address width (`RegAddrBus`); register count is 2^ADDR_W
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid_i  in  1  result offered
- in_ready_o  out  1  queue can accept; = !full, forced 0 while rst = 0
- in_addr_i  in  ADDR_W  destination register
- in_data_i  in  DATA_W  result value
- hold_i  in  1  write port borrowed by monitor/debug; suppresses drain
- wEnable_o  out  1  register file write enable (registered)
- wAddr_o  out  ADDR_W  register file write address (registered)
- wData_o  out  DATA_W  register file write data (registered)
- pending_o  out  2^ADDR_W  bit r = 1 iff a queued entry targets register r
- fwd_addr_i  in  ADDR_W  forwarding lookup address
- fwd_hit_o  out  1  youngest queued entry matching fwd_addr_i exists
- fwd_data_o  out  DATA_W  data of that entry, else 0
- count_o  out  clog2(DEPTH)+1  occupancy

## Operation
- Accept on the edge where in_valid_i && in_ready_o.
- in_addr_i = 0 (`RegZero`) is accepted but discarded: no enqueue, no pending bit set, count unchanged.
- Drain on each edge where !hold_i && !empty:
  - wEnable_o ← 1; wAddr_o/wData_o ← head; head pointer advances.
  - Otherwise wEnable_o ← 0 and wAddr_o/wData_o keep their previous values.
- Entries drain strictly in acceptance order. Two entries to the same register both write; the younger one lands last.
- Simultaneous accept and drain:
  - Allowed whenever not full; count is unchanged.
  - At full, in_ready_o = 0, so accept is blocked even if a drain happens on the same edge. There is no pass-through.
- Pointers wrap modulo DEPTH. count_o distinguishes full from empty.
- pending_o and the forward outputs are combinational from queue state only.
  - The output register is not included, because the register file bypasses its own write port.
  - Register 0 is never pending.
- Forward match priority: youngest entry (closest to tail) wins.

## Timing
- Reset (asynchronous assert, synchronous release): pointers = 0, count_o = 0, wEnable_o = 0, wAddr_o = 0, wData_o = 0, pending_o = 0, fwd_hit_o = 0, fwd_data_o = 0.
- Reset mid-operation discards all queued entries, and any write in flight is dropped.
- Latency with empty queue and hold_i = 0:
  - Accept at edge k.
  - wEnable_o high in the cycle after edge k+1.
  - Register file commits at edge k+2.
- Throughput: one write per cycle sustained.
- hold_i asserted for n cycles delays the drain by exactly n cycles. Accepts continue until full.
- pending bit for r:
  - sets in the cycle after the accepting edge;
  - clears in the cycle after the draining edge of the last queued entry targeting r.

## Configuration
- WB_QUEUE_FORWARD_EN defined: the forwarding comparator over all DEPTH entries is built, and fwd_hit_o/fwd_data_o behave as above.
- Not defined: fwd_hit_o = 0 and fwd_data_o = 0 constantly, and fwd_addr_i is ignored. Decode must then stall on pending_o. All other behaviour is identical.

## Structure
- Shared package/defines (defines.v): `RegBus`, `RegAddrBus`, `RegZero`, `ZeroWord`, `WriteEnable`, and a new `WbQueueDepth` default.
- Entry record (valid, addr, data) defined locally.
- One sub-module: wb_queue_fifo, a parameterised circular buffer with pointers, count and full/empty that exposes all entries for the pending/forward scan. The top level holds the handshake, drain register and scan logic.

## Test plan
- Single write: accept (addr 3, data 0x1234) into an empty queue → wEnable_o = 1, wAddr_o = 3, wData_o = 0x1234 exactly one cycle later, for one cycle; pending_o[3] high for one cycle.
- Fill/backpressure with DEPTH = 4 and hold_i = 1:
  - Offer 5 writes (addr 1–5) → in_ready_o drops after the 4th, count_o = 4.
  - Release hold → writes 1, 2, 3, 4 emerge on consecutive cycles, then the 5th is accepted and written.
- Same-register ordering: writes r2 = 0xAAAA then r2 = 0xBBBB with hold_i = 1 → fwd_addr_i = 2 gives fwd_hit_o = 1, fwd_data_o = 0xBBBB; drain order is 0xAAAA then 0xBBBB.
- Zero register: offer addr 0, data 0xFFFF → in_ready_o = 1, count_o stays 0, no wEnable_o pulse.
- Wrap with simultaneous accept/drain: stream 10 back-to-back writes with hold_i = 0 → count_o stays ≤ 1, all 10 emerge in order, pointers wrap twice.
- Mid-operation reset: queue 3 entries, pull rst low → all outputs 0 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/wb_write_queue_pkg.sv
// rtl/wb_write_queue_pkg.sv - shared core widths and write-back queue defaults
package wb_write_queue_pkg;

    localparam int REG_BUS        = 16;
    localparam int REG_ADDR_BUS   = 4;
    localparam int WB_QUEUE_DEPTH = 4;

    localparam logic [REG_ADDR_BUS-1:0] REG_ZERO     = '0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
    localparam logic                    WRITE_ENABLE = 1'b1;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_queue_fifo.sv
// rtl/wb_queue_fifo.sv - circular buffer of (valid, addr, data) entries with every slot exposed
module wb_queue_fifo
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = WB_QUEUE_DEPTH,
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = count_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [CNT_W-1:0]               count,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic [PTR_W-1:0]               rd_ptr,
    output logic [DEPTH-1:0]               slot_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   slot_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]   slot_data
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem[rd_ptr].addr;
    assign head_data = mem[rd_ptr].data;

    always_comb begin
        slot_valid = '0;
        slot_addr  = '0;
        slot_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = mem[i].valid;
            slot_addr[i]  = mem[i].addr;
            slot_data[i]  = mem[i].data;
        end
    end

    // Callers never push when full or pop when empty, so both pointers never collide on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order write-back queue to the register file; WB_QUEUE_FORWARD_EN adds forwarding
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = WB_QUEUE_DEPTH,
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ADDR_W-1:0]         in_addr_i,
    input  logic [DATA_W-1:0]         in_data_i,
    input  logic                      hold_i,
    output logic                      wEnable_o,
    output logic [ADDR_W-1:0]         wAddr_o,
    output logic [DATA_W-1:0]         wData_o,
    output logic [(1<<ADDR_W)-1:0]    pending_o,
    input  logic [ADDR_W-1:0]         fwd_addr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_W-1:0]         fwd_data_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [PTR_W-1:0]             rd_ptr;
    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] slot_addr;
    logic [DEPTH-1:0][DATA_W-1:0] slot_data;

    assign in_ready_o = rst & ~full;
    // Writes to the zero register complete the handshake but never occupy a slot.
    assign push = in_valid_i & in_ready_o & (in_addr_i != ADDR_W'(REG_ZERO));
    assign pop  = ~hold_i & ~empty;

    wb_queue_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (in_addr_i),
        .push_data  (in_data_i),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .count      (count_o),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .rd_ptr     (rd_ptr),
        .slot_valid (slot_valid),
        .slot_addr  (slot_addr),
        .slot_data  (slot_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wEnable_o <= 1'b0;
            wAddr_o   <= '0;
            wData_o   <= DATA_W'(ZERO_WORD);
        end else if (pop) begin
            wEnable_o <= WRITE_ENABLE;
            wAddr_o   <= head_addr;
            wData_o   <= head_data;
        end else begin
            wEnable_o <= 1'b0;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pending_o[slot_addr[i]] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

`ifdef WB_QUEUE_FORWARD_EN
    // Walk oldest to youngest so the last match, the youngest entry, wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit_o  = 1'b0;
        fwd_data_o = DATA_W'(ZERO_WORD);
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (slot_valid[idx] && slot_addr[idx] == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = slot_data[idx];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_i, rd_ptr, slot_data};
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = DATA_W'(ZERO_WORD);
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_addr_i;
    logic [15:0] in_data_i;
    logic        hold_i;
    logic        wEnable_o;
    logic [3:0]  wAddr_o;
    logic [15:0] wData_o;
    logic [15:0] pending_o;
    logic [3:0]  fwd_addr_i;
    logic        fwd_hit_o;
    logic [15:0] fwd_data_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_write_queue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_addr_i  (in_addr_i),
        .in_data_i  (in_data_i),
        .hold_i     (hold_i),
        .wEnable_o  (wEnable_o),
        .wAddr_o    (wAddr_o),
        .wData_o    (wData_o),
        .pending_o  (pending_o),
        .fwd_addr_i (fwd_addr_i),
        .fwd_hit_o  (fwd_hit_o),
        .fwd_data_o (fwd_data_o),
        .count_o    (count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [15:0] d);
        in_valid_i = 1'b1;
        in_addr_i  = a;
        in_data_i  = d;
    endtask

    initial begin
        rst        = 1'b0;
        in_valid_i = 1'b0;
        in_addr_i  = '0;
        in_data_i  = '0;
        hold_i     = 1'b0;
        fwd_addr_i = '0;
        step();
        step();
        check("rst_count",   count_o,    0);
        check("rst_wen",     wEnable_o,  0);
        check("rst_waddr",   wAddr_o,    0);
        check("rst_wdata",   wData_o,    0);
        check("rst_pending", pending_o,  0);
        check("rst_ready",   in_ready_o, 0);
        check("rst_fwd_hit", fwd_hit_o,  0);
        rst = 1'b1;
        step();
        check("idle_ready", in_ready_o, 1);

        // single write
        offer(4'd3, 16'h1234);
        step();
        in_valid_i = 1'b0;
        check("single_count", count_o, 1);
        check("single_pend",  pending_o, 16'h0008);
        check("single_wen0",  wEnable_o, 0);
        step();
        check("single_wen",   wEnable_o, 1);
        check("single_waddr", wAddr_o, 3);
        check("single_wdata", wData_o, 16'h1234);
        check("single_pend0", pending_o, 0);
        step();
        check("single_wen_off", wEnable_o, 0);
        check("single_hold_addr", wAddr_o, 3);

        // fill with hold, fifth write back-pressured
        hold_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(4'(i), 16'h0100 + 16'(i));
            #1;
            check($sformatf("fill_ready_%0d", i), in_ready_o, (i <= 4) ? 1 : 0);
            if (i < 5) step();
        end
        check("fill_count", count_o, 4);
        check("fill_pend",  pending_o, 16'h001E);
        check("fill_wen",   wEnable_o, 0);
        hold_i = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            if (j == 2) in_valid_i = 1'b0;
            check($sformatf("drain_wen_%0d", j),  wEnable_o, 1);
            check($sformatf("drain_addr_%0d", j), wAddr_o, j);
            check($sformatf("drain_data_%0d", j), wData_o, 32'h0100 + j);
        end
        step();
        check("drain_done_wen",   wEnable_o, 0);
        check("drain_done_count", count_o, 0);

        // same-register ordering and forwarding
        hold_i = 1'b1;
        offer(4'd2, 16'hAAAA);
        step();
        offer(4'd2, 16'hBBBB);
        step();
        in_valid_i = 1'b0;
        fwd_addr_i = 4'd2;
        #1;
        check("same_count", count_o, 2);
        check("same_pend",  pending_o, 16'h0004);
`ifdef WB_QUEUE_FORWARD_EN
        check("fwd_hit",  fwd_hit_o, 1);
        check("fwd_data", fwd_data_o, 16'hBBBB);
`else
        check("fwd_hit_off",  fwd_hit_o, 0);
        check("fwd_data_off", fwd_data_o, 0);
`endif
        fwd_addr_i = 4'd3;
        #1;
        check("fwd_miss_hit",  fwd_hit_o, 0);
        check("fwd_miss_data", fwd_data_o, 0);
        hold_i = 1'b0;
        step();
        check("same_first",      wData_o, 16'hAAAA);
        check("same_pend_still", pending_o, 16'h0004);
        step();
        check("same_second", wData_o, 16'hBBBB);
        check("same_pend0",  pending_o, 0);
        step();

        // zero register is accepted and dropped
        offer(4'd0, 16'hFFFF);
        #1;
        check("zero_ready", in_ready_o, 1);
        step();
        in_valid_i = 1'b0;
        check("zero_count", count_o, 0);
        check("zero_pend",  pending_o, 0);
        step();
        check("zero_wen", wEnable_o, 0);

        // back-to-back stream through wrapping pointers
        for (int i = 0; i < 10; i++) begin
            offer(4'((i % 15) + 1), 16'hC000 + 16'(i));
            step();
            check($sformatf("stream_count_%0d", i), count_o, 1);
            if (i > 0) begin
                check($sformatf("stream_wen_%0d", i),  wEnable_o, 1);
                check($sformatf("stream_data_%0d", i), wData_o, 32'hC000 + i - 1);
            end
        end
        in_valid_i = 1'b0;
        step();
        check("stream_last_data", wData_o, 16'hC009);
        check("stream_last_addr", wAddr_o, 10);
        check("stream_empty",     count_o, 0);
        step();

        // reset mid-operation with a write in flight
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(4'(7 + i), 16'hD000 + 16'(i));
            step();
        end
        in_valid_i = 1'b0;
        check("mid_count", count_o, 3);
        hold_i = 1'b0;
        step();
        check("mid_inflight", wEnable_o, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", count_o, 0);
        check("mid_rst_wen",   wEnable_o, 0);
        check("mid_rst_waddr", wAddr_o, 0);
        check("mid_rst_wdata", wData_o, 0);
        check("mid_rst_pend",  pending_o, 0);
        check("mid_rst_ready", in_ready_o, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst_wen_%0d", i), wEnable_o, 0);
        end
        check("post_rst_count", count_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
